// File: rtl/lpt_seq_datapath_if.sv
// Handshake/bus bundle for lpt_seq_datapath.
// master: start/op/rd/rs/rt/in out, busy/done/flags/out in; slave is the mirror.
interface lpt_seq_datapath_if #(
   parameter int W    = 8,
   parameter int NREG = 4
);
   localparam int RA = $clog2(NREG);

   logic          start;
   logic [2:0]    op;
   logic [RA-1:0] rd;
   logic [RA-1:0] rs;
   logic [RA-1:0] rt;
   logic [W-1:0]  in;
   logic          busy;
   logic          done;
   logic [2:0]    flags;
   logic [W-1:0]  out;

   modport master (
      output start, op, rd, rs, rt, in,
      input  busy, done, flags, out
   );

   modport slave (
      input  start, op, rd, rs, rt, in,
      output busy, done, flags, out
   );
endinterface

// File: rtl/lpt_seq_datapath.sv
// Sequenced register-file / tmp / ALU datapath: one start runs Rd = op(Rs, Rt).
// Ports: clk, reset (sync active-high), bus (slave: command in; busy/done/flags/out).
module lpt_seq_datapath #(
   parameter int W    = 8,
   parameter int NREG = 4
) (
   input logic                clk,
   input logic                reset,
   lpt_seq_datapath_if.slave  bus
);
   localparam int RA = $clog2(NREG);

   localparam logic [2:0] OP_XOR  = 3'b000;
   localparam logic [2:0] OP_AND  = 3'b001;
   localparam logic [2:0] OP_SHL  = 3'b010;
   localparam logic [2:0] OP_PASS = 3'b011;
   localparam logic [2:0] OP_ADD  = 3'b100;
   localparam logic [2:0] OP_SUB  = 3'b101;
   localparam logic [2:0] OP_LDI  = 3'b110;
   localparam logic [2:0] OP_SHR  = 3'b111;

   typedef enum logic [1:0] {
      IDLE,
      LOADA,
      EXEC,
      WRITE
   } state_t;

   typedef struct packed {
      logic [2:0]    op;
      logic [RA-1:0] rd;
      logic [RA-1:0] rs;
      logic [RA-1:0] rt;
      logic [W-1:0]  imm;
   } cmd_t;

   state_t       state;
   state_t       nxt;
   cmd_t         cmd;
   logic [W-1:0] regs [NREG];
   logic [W-1:0] tmp;
   logic [W-1:0] res;
   logic [W-1:0] out_q;
   logic [2:0]   flags_q;
   logic         done_q;

   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [W-1:0] alu_res;
   logic         alu_v;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= nxt;
      end
   end

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:  if (bus.start) nxt = LOADA;
         LOADA: nxt = EXEC;
         EXEC:  nxt = WRITE;
         WRITE: nxt = IDLE;
      endcase
   end

   // B is read straight from the file at the EXEC edge, so an Rd that
   // aliases Rt still supplies its pre-write value.
   assign a = tmp;
   assign b = regs[cmd.rt];

   always_comb begin
      alu_res = '0;
      alu_v   = 1'b0;
      unique case (cmd.op)
         OP_XOR:  alu_res = a ^ b;
         OP_AND:  alu_res = a & b;
         OP_SHL:  alu_res = {a[W-2:0], 1'b0};
         OP_PASS: alu_res = b;
         OP_ADD: begin
            alu_res = a + b;
            alu_v   = (a[W-1] == b[W-1]) && (alu_res[W-1] != a[W-1]);
         end
         OP_SUB: begin
            alu_res = a - b;
            alu_v   = (a[W-1] != b[W-1]) && (alu_res[W-1] != a[W-1]);
         end
         OP_LDI:  alu_res = cmd.imm;
         OP_SHR:  alu_res = {1'b0, a[W-1:1]};
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
         tmp     <= '0;
         res     <= '0;
         out_q   <= '0;
         flags_q <= '0;
         done_q  <= 1'b0;
         cmd     <= '0;
      end else begin
         done_q <= (state == WRITE);
         out_q  <= regs[0];
         unique case (state)
            IDLE: begin
               if (bus.start) begin
                  cmd.op  <= bus.op;
                  cmd.rd  <= bus.rd;
                  cmd.rs  <= bus.rs;
                  cmd.rt  <= bus.rt;
                  cmd.imm <= bus.in;
               end
            end
            LOADA: tmp <= regs[cmd.rs];
            EXEC: begin
               res     <= alu_res;
               flags_q <= {alu_res == '0, alu_res[W-1], alu_v};
            end
            WRITE: regs[cmd.rd] <= res;
         endcase
      end
   end

   assign bus.busy  = (state != IDLE);
   assign bus.done  = done_q;
   assign bus.flags = flags_q;
   assign bus.out   = out_q;
endmodule

// File: tb/tb_lpt_seq_datapath.sv
// Directed bench for lpt_seq_datapath: vector table plus handshake/reset sequences.
// Two instances: W=8/NREG=4 and W=16/NREG=8.
module tb_lpt_seq_datapath;
   localparam logic [2:0] XOR_ = 3'b000;
   localparam logic [2:0] AND_ = 3'b001;
   localparam logic [2:0] SHL_ = 3'b010;
   localparam logic [2:0] PAS_ = 3'b011;
   localparam logic [2:0] ADD_ = 3'b100;
   localparam logic [2:0] SUB_ = 3'b101;
   localparam logic [2:0] LDI_ = 3'b110;
   localparam logic [2:0] SHR_ = 3'b111;

   logic clk;
   logic reset;
   int   tests;
   int   failed;

   lpt_seq_datapath_if #(.W(8), .NREG(4))  ba ();
   lpt_seq_datapath_if #(.W(16), .NREG(8)) bb ();

   lpt_seq_datapath #(.W(8), .NREG(4)) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (ba)
   );

   lpt_seq_datapath #(.W(16), .NREG(8)) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (bb)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [2:0]  op;
      int          rd;
      int          rs;
      int          rt;
      logic [31:0] imm;
      logic [31:0] exp;
      logic [2:0]  fl;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input int inst, input logic s, input logic [2:0] o,
                        input int d, input int x, input int y,
                        input logic [31:0] imm);
      if (inst == 0) begin
         ba.start = s;
         ba.op    = o;
         ba.rd    = d[1:0];
         ba.rs    = x[1:0];
         ba.rt    = y[1:0];
         ba.in    = imm[7:0];
      end else begin
         bb.start = s;
         bb.op    = o;
         bb.rd    = d[2:0];
         bb.rs    = x[2:0];
         bb.rt    = y[2:0];
         bb.in    = imm[15:0];
      end
   endtask

   function automatic logic get_done(input int inst);
      return (inst == 0) ? ba.done : bb.done;
   endfunction

   function automatic logic get_busy(input int inst);
      return (inst == 0) ? ba.busy : bb.busy;
   endfunction

   function automatic logic [2:0] get_flags(input int inst);
      return (inst == 0) ? ba.flags : bb.flags;
   endfunction

   function automatic logic [31:0] get_out(input int inst);
      return (inst == 0) ? {24'h0, ba.out} : {16'h0, bb.out};
   endfunction

   // Counts negedges since the start edge until done shows; bounded.
   task automatic wait_done(input int inst, input int n0, output int lat);
      lat = n0;
      while (!get_done(inst) && lat < 20) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic run_op(input int inst, input logic [2:0] o, input int d,
                         input int x, input int y, input logic [31:0] imm,
                         output int lat);
      @(negedge clk);
      drive(inst, 1'b1, o, d, x, y, imm);
      @(negedge clk);
      drive(inst, 1'b0, 3'b000, 0, 0, 0, 32'h0);
      wait_done(inst, 1, lat);
   endtask

   // Copies R[r] into R0 with PASS, then reads it one cycle later on out.
   task automatic observe(input int inst, input int r, output logic [31:0] v);
      int lat;
      run_op(inst, PAS_, 0, 0, r, 32'h0, lat);
      @(negedge clk);
      v = get_out(inst);
   endtask

   vec_t va [17];
   vec_t vb [3];

   initial begin
      int          lat;
      int          cnt;
      logic [31:0] v;
      string       nm;

      tests  = 0;
      failed = 0;

      //            op    rd rs rt imm    exp    {Z,N,V}
      va[0]  = '{LDI_, 1, 0, 0, 32'h70, 32'h70, 3'b000};
      va[1]  = '{LDI_, 2, 0, 0, 32'h20, 32'h20, 3'b000};
      va[2]  = '{ADD_, 0, 1, 2, 32'h00, 32'h90, 3'b011};
      va[3]  = '{LDI_, 1, 0, 0, 32'h55, 32'h55, 3'b000};
      va[4]  = '{SUB_, 3, 1, 1, 32'h00, 32'h00, 3'b100};
      va[5]  = '{LDI_, 2, 0, 0, 32'h81, 32'h81, 3'b010};
      va[6]  = '{SHL_, 2, 2, 0, 32'h00, 32'h02, 3'b000};
      va[7]  = '{SHR_, 2, 2, 0, 32'h00, 32'h01, 3'b000};
      va[8]  = '{XOR_, 3, 1, 2, 32'h00, 32'h54, 3'b000};
      va[9]  = '{AND_, 3, 3, 1, 32'h00, 32'h54, 3'b000};
      va[10] = '{SUB_, 1, 2, 1, 32'h00, 32'hAC, 3'b010};
      va[11] = '{LDI_, 3, 0, 0, 32'h01, 32'h01, 3'b000};
      va[12] = '{LDI_, 2, 0, 0, 32'h80, 32'h80, 3'b010};
      va[13] = '{SUB_, 1, 2, 3, 32'h00, 32'h7F, 3'b001};
      va[14] = '{PAS_, 0, 0, 1, 32'h00, 32'h7F, 3'b000};
      va[15] = '{ADD_, 0, 2, 2, 32'h00, 32'h00, 3'b101};
      va[16] = '{SHR_, 3, 2, 0, 32'h00, 32'h40, 3'b000};

      vb[0] = '{LDI_, 5, 0, 0, 32'h7000, 32'h7000, 3'b000};
      vb[1] = '{LDI_, 6, 0, 0, 32'h1000, 32'h1000, 3'b000};
      vb[2] = '{ADD_, 7, 5, 6, 32'h0000, 32'h8000, 3'b011};

      // reset held 2 cycles with start high
      reset = 1'b1;
      drive(0, 1'b1, LDI_, 0, 0, 0, 32'hFF);
      drive(1, 1'b1, LDI_, 0, 0, 0, 32'hFFFF);
      @(negedge clk);
      @(negedge clk);
      check("rst_out", get_out(0), 32'h0);
      check("rst_flags", {29'h0, get_flags(0)}, 32'h0);
      check("rst_busy", {31'h0, get_busy(0)}, 32'h0);
      check("rst_done", {31'h0, get_done(0)}, 32'h0);
      reset = 1'b0;
      drive(0, 1'b0, 3'b000, 0, 0, 0, 32'h0);
      drive(1, 1'b0, 3'b000, 0, 0, 0, 32'h0);
      @(negedge clk);
      check("rst_nostart", {31'h0, get_busy(0)}, 32'h0);
      check("rst_r0", get_out(0), 32'h0);

      for (int i = 0; i < 17; i++) begin
         run_op(0, va[i].op, va[i].rd, va[i].rs, va[i].rt, va[i].imm, lat);
         nm = $sformatf("v%0d", i);
         check({nm, "_lat"}, lat, 4);
         check({nm, "_busy"}, {31'h0, get_busy(0)}, 32'h0);
         check({nm, "_flags"}, {29'h0, get_flags(0)}, {29'h0, va[i].fl});
         if (va[i].rd == 0) begin
            @(negedge clk);
            v = get_out(0);
         end else begin
            observe(0, va[i].rd, v);
         end
         check({nm, "_val"}, v, va[i].exp);
      end

      // start during busy is ignored
      @(negedge clk);
      drive(0, 1'b1, LDI_, 3, 0, 0, 32'h11);
      @(negedge clk);
      drive(0, 1'b1, LDI_, 3, 0, 0, 32'hEE);
      @(negedge clk);
      drive(0, 1'b0, 3'b000, 0, 0, 0, 32'h0);
      wait_done(0, 2, lat);
      check("ign_lat", lat, 4);
      @(negedge clk);
      check("ign_idle", {31'h0, get_busy(0)}, 32'h0);
      observe(0, 3, v);
      check("ign_r3", v, 32'h11);

      // start held through done: back-to-back acceptance
      @(negedge clk);
      drive(0, 1'b1, LDI_, 1, 0, 0, 32'h33);
      @(negedge clk);
      drive(0, 1'b1, LDI_, 2, 0, 0, 32'h44);
      wait_done(0, 1, lat);
      check("b2b_lat1", lat, 4);
      check("b2b_gap", {31'h0, get_busy(0)}, 32'h0);
      @(negedge clk);
      check("b2b_busy2", {31'h0, get_busy(0)}, 32'h1);
      check("b2b_done2", {31'h0, get_done(0)}, 32'h0);
      drive(0, 1'b0, 3'b000, 0, 0, 0, 32'h0);
      wait_done(0, 1, lat);
      check("b2b_lat2", lat, 4);
      observe(0, 1, v);
      check("b2b_r1", v, 32'h33);
      observe(0, 2, v);
      check("b2b_r2", v, 32'h44);

      // reset during EXEC aborts the op
      @(negedge clk);
      drive(0, 1'b1, ADD_, 3, 1, 2, 32'h0);
      @(negedge clk);
      drive(0, 1'b0, 3'b000, 0, 0, 0, 32'h0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("mid_flags", {29'h0, get_flags(0)}, 32'h0);
      check("mid_out", get_out(0), 32'h0);
      check("mid_busy", {31'h0, get_busy(0)}, 32'h0);
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (get_done(0)) cnt++;
      end
      check("mid_nodone", cnt, 0);
      observe(0, 3, v);
      check("mid_r3", v, 32'h0);
      observe(0, 1, v);
      check("mid_r1", v, 32'h0);

      // wide instance
      for (int i = 0; i < 3; i++) begin
         run_op(1, vb[i].op, vb[i].rd, vb[i].rs, vb[i].rt, vb[i].imm, lat);
         nm = $sformatf("w%0d", i);
         check({nm, "_lat"}, lat, 4);
         check({nm, "_flags"}, {29'h0, get_flags(1)}, {29'h0, vb[i].fl});
         observe(1, vb[i].rd, v);
         check({nm, "_val"}, v, vb[i].exp);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule

// File: doc/lpt_seq_datapath.md
# lpt_seq_datapath

Parametrised successor to the lab register-file/tmp/ALU datapath. A sequencer runs a whole register-to-register operation from a single `start` pulse: read Rs into tmp, combine with Rt, write Rd. It adds configurable width and register count, add/sub/shift-right ops, status flags and a busy/done handshake. It sits between the lab top-level switch/LED wrapper and the register file it owns.

## Interface
- `W`, 8, data width in bits (4..32).
- `NREG`, 4, number of general registers; power of two, 2..16.
- `RA`, `$clog2(NREG)`, register-address width (derived; do not override).
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset; sampled on `clk` rising edge.
- `start`  in  1  request a new operation; honoured only in IDLE.
- `op`  in  3  operation code, captured with `start`.
- `rd`, `rs`, `rt`  in  RA each  destination / A-source / B-source register, captured with `start`.
- `in`  in  W  immediate operand, captured with `start` (used by LDI).
- `busy`  out  1  high while an operation is in flight.
- `done`  out  1  one-cycle pulse: Rd has been written.
- `flags`  out  3  {Z, N, V} from the last completed EXEC.
- `out`  out  W  registered copy of R0, updated every cycle.

## Operation
- Storage: R[0..NREG-1] (W bits each), tmp (W), res (W), and captured op/rd/rs/rt/imm.
- FSM states:
  - IDLE: `start`=1 captures op, rd, rs, rt and in, then goes to LOADA. Otherwise stays in IDLE.
  - LOADA: tmp <= R[rs]; go to EXEC.
  - EXEC: res <= ALU(tmp, R[rt]); flags <= f(res); go to WRITE.
  - WRITE: R[rd] <= res; done <= 1; go to IDLE.
- ALU ops, with A = tmp and B = R[rt]; all results modulo 2^W:
  - 000 XOR: A^B.
  - 001 AND: A&B.
  - 010 SHL: A<<1, LSB filled with 0.
  - 011 PASS: B.
  - 100 ADD: A+B.
  - 101 SUB: A-B.
  - 110 LDI: captured imm.
  - 111 SHR: logical A>>1, MSB filled with 0.
- Flags:
  - Z = (res==0).
  - N = res[W-1].
  - V, ADD: A[W-1]==B[W-1] and res[W-1]!=A[W-1].
  - V, SUB: A[W-1]!=B[W-1] and res[W-1]!=A[W-1].
  - V = 0 for all other ops.
  - Flags hold their value outside EXEC.
- `busy` = (state != IDLE). `done` is registered and high only in the cycle after the WRITE edge.
- Rd, Rs and Rt may alias. Rs is read at the LOADA edge and Rt at the EXEC edge, so both see register values from before this op's write.
- `start` while busy is ignored; it is not queued.

## Timing
- Reset (any cycle, including mid-operation):
  - R[*], tmp, res, flags and `out` go to 0; `busy`=0, `done`=0; state goes to IDLE.
  - An aborted operation writes nothing.
- Latency: with `start` sampled at edge E0, tmp loads at E1, res/flags at E2 and R[rd] at E3. `done`=1 and `busy`=0 during the cycle E3..E4.
- Back-to-back operation: `start` may be asserted during the `done` cycle and is accepted at E4. Sustained throughput is one operation per 4 cycles.
- `out` lags R0 by one cycle: a write to R0 at E3 appears on `out` after E4.
- `busy` is high for exactly 3 cycles per operation (E0..E3).
- `reset` has priority over `start` in the same cycle.

## Test plan
- Reset with W=8, NREG=4: hold `reset` 2 cycles with `start`=1 -> `out`=0, `flags`=000, `busy`=0, `done`=0; no operation starts.
- LDI then ADD overflow:
  - LDI R1=0x70, then LDI R2=0x20 -> `done` pulses 4 cycles after each `start`.
  - ADD rd=0, rs=1, rt=2 -> R0=0x90, `flags`={0,1,1}; `out`=0x90 one cycle after `done`.
- SUB to zero: R1=0x55, op=SUB rd=3, rs=1, rt=1 -> R3=0x00, `flags`={1,0,0}.
- Shifts and aliasing:
  - R2=0x81, op=SHL rd=2, rs=2 -> R2=0x02.
  - Then op=SHR rd=2, rs=2 -> R2=0x01, `flags`={0,0,0}.
- Handshake:
  - `start` pulsed during busy with a different op -> ignored, R unchanged.
  - `start` held high through `done` -> second op accepted at E4, `busy` low for exactly the one `done` cycle.
- Mid-op reset and parameters:
  - Assert `reset` during EXEC of ADD rd=3 -> R3 stays 0, `done` never pulses.
  - Rerun the ADD overflow case with W=16, NREG=8: LDI R5=0x7000 and R6=0x1000, ADD rd=7, rs=5, rt=6 -> R7=0x8000, `flags`={0,1,1}.
